// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results and extracts/extends load data into the register file write port.
// One-cycle write latency; instr_ready low while a load waits for memory. Optional bypass via `WB_BYPASS_EN.
module wb_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [1:0]            instr_kind,
   input  logic [4:0]            instr_rd,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [2:0]            load_funct3,
   input  logic [1:0]            load_byte_off,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [4:0]            rd_addr1,
   input  logic [4:0]            rd_addr2,
   output logic                  wr_en,
   output logic [4:0]            rw_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  stall,
   output logic                  load_misaligned
`ifdef WB_BYPASS_EN
   ,
   output logic                  byp_hit1,
   output logic                  byp_hit2,
   output logic [DATA_WIDTH-1:0] byp_data
`endif
);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_MEM = 1'b1;

   localparam logic [1:0] KIND_ALU  = 2'b01;
   localparam logic [1:0] KIND_LOAD = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [0:0]            state_q, state_d;
   logic                  wr_en_q, wr_en_d;
   logic [4:0]            rw_addr_q, rw_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  misaligned_q, misaligned_d;
   logic [4:0]            pending_rd_q, pending_rd_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            off_q, off_d;

   logic                  accept;
   logic                  load_ok;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  pend_hit;
   logic                  wr_hit;

   assign instr_ready = (state_q == IDLE);
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      load_ok = 1'b0;
      case (load_funct3)
         F3_LB, F3_LBU: load_ok = 1'b1;
         F3_LH, F3_LHU: load_ok = ~load_byte_off[0];
         F3_LW:         load_ok = (load_byte_off == 2'b00);
         default:       load_ok = 1'b0;
      endcase
   end

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_data = mem_rdata;
      case (funct3_q)
         F3_LB:   load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      wr_en_d      = 1'b0;
      rw_addr_d    = rw_addr_q;
      wr_data_d    = wr_data_q;
      misaligned_d = 1'b0;
      pending_rd_d = pending_rd_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (instr_kind == KIND_ALU && instr_rd != 5'd0) begin
                  wr_en_d   = 1'b1;
                  rw_addr_d = instr_rd;
                  wr_data_d = alu_result;
               end else if (instr_kind == KIND_LOAD) begin
                  if (load_ok) begin
                     pending_rd_d = instr_rd;
                     funct3_d     = load_funct3;
                     off_d        = load_byte_off;
                     state_d      = WAIT_MEM;
                  end else begin
                     misaligned_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            if (mem_rvalid) begin
               // A load to x0 still consumes the memory response but writes nothing.
               if (pending_rd_q != 5'd0) begin
                  wr_en_d   = 1'b1;
                  rw_addr_d = pending_rd_q;
                  wr_data_d = load_data;
               end
               pending_rd_d = 5'd0;
               state_d      = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_en_q      <= 1'b0;
         rw_addr_q    <= 5'd0;
         wr_data_q    <= '0;
         misaligned_q <= 1'b0;
         pending_rd_q <= 5'd0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_en_d;
         rw_addr_q    <= rw_addr_d;
         wr_data_q    <= wr_data_d;
         misaligned_q <= misaligned_d;
         pending_rd_q <= pending_rd_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
      end
   end

   assign wr_en           = wr_en_q;
   assign rw_addr         = rw_addr_q;
   assign wr_data         = wr_data_q;
   assign load_misaligned = misaligned_q;

   assign pend_hit = (state_q == WAIT_MEM) && (pending_rd_q != 5'd0) &&
                     ((rd_addr1 == pending_rd_q) || (rd_addr2 == pending_rd_q));
   assign wr_hit   = wr_en_q && (rw_addr_q != 5'd0) &&
                     ((rw_addr_q == rd_addr1) || (rw_addr_q == rd_addr2));

`ifdef WB_BYPASS_EN
   assign byp_hit1 = wr_en_q && (rw_addr_q == rd_addr1) && (rd_addr1 != 5'd0);
   assign byp_hit2 = wr_en_q && (rw_addr_q == rd_addr2) && (rd_addr2 != 5'd0);
   assign byp_data = wr_data_q;
   assign stall    = pend_hit;
   logic unused_wr_hit;
   assign unused_wr_hit = wr_hit;
`else
   // Without bypass the register file returns the stale value during the write cycle.
   assign stall = pend_hit | wr_hit;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register writes are queued at issue and checked by a monitor.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [1:0]  instr_kind = 2'b00;
   logic [4:0]  instr_rd = 5'd0;
   logic [31:0] alu_result = '0;
   logic [2:0]  load_funct3 = 3'd0;
   logic [1:0]  load_byte_off = 2'd0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  rd_addr1 = 5'd0;
   logic [4:0]  rd_addr2 = 5'd0;
   logic        wr_en;
   logic [4:0]  rw_addr;
   logic [31:0] wr_data;
   logic        stall;
   logic        load_misaligned;
`ifdef WB_BYPASS_EN
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] exp_q[$];

   wb_stage #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_kind(instr_kind), .instr_rd(instr_rd), .alu_result(alu_result),
      .load_funct3(load_funct3), .load_byte_off(load_byte_off),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .wr_en(wr_en), .rw_addr(rw_addr), .wr_data(wr_data),
      .stall(stall), .load_misaligned(load_misaligned)
`ifdef WB_BYPASS_EN
      , .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every write pulse seen must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {rw_addr, wr_data}, 37'h0);
            if ({rw_addr, wr_data} == 37'h0) begin
               n_fail++;
               $display("FAIL unexpected_write: got write to x0, expected none");
            end
         end else begin
            check("sb_write", {rw_addr, wr_data}, exp_q.pop_front());
         end
      end
   end

   task automatic issue_alu(input logic [4:0] rd, input logic [31:0] val);
      if (rd != 5'd0) exp_q.push_back({rd, val});
      instr_valid = 1'b1; instr_kind = 2'b01; instr_rd = rd; alu_result = val;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
      instr_valid = 1'b1; instr_kind = 2'b10; instr_rd = rd;
      load_funct3 = f3; load_byte_off = off;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic mem_resp(input logic [31:0] data, input int delay);
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = data;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
   endtask

   task automatic load_case(input string name, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] data, input logic [31:0] exp);
      exp_q.push_back({rd, exp});
      issue_load(rd, f3, off);
      mem_resp(data, 1);
      @(negedge clk);
      check(name, {36'h0, wr_en}, 37'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #12;
      check("rst_wr_en",   {36'h0, wr_en}, 37'h0);
      check("rst_rw_addr", {32'h0, rw_addr}, 37'h0);
      check("rst_wr_data", {5'h0, wr_data}, 37'h0);
      check("rst_mis",     {36'h0, load_misaligned}, 37'h0);
      check("rst_ready",   {36'h0, instr_ready}, 37'h1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU write, then rd=0 write suppressed
      issue_alu(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      check("alu_wr_en", {36'h0, wr_en}, 37'h1);
      @(negedge clk);
      check("alu_pulse_end", {36'h0, wr_en}, 37'h0);
      issue_alu(5'd0, 32'h12345678);
      @(negedge clk);
      check("x0_no_write", {36'h0, wr_en}, 37'h0);
      @(posedge clk); #1;

      load_case("lb",  5'd1, 3'b000, 2'd2, 32'h0080FF00, 32'hFFFFFF80);
      load_case("lbu", 5'd2, 3'b100, 2'd2, 32'h0080FF00, 32'h00000080);
      load_case("lhu", 5'd3, 3'b101, 2'd2, 32'h0080FF00, 32'h00000080);
      load_case("lh",  5'd4, 3'b001, 2'd2, 32'h80001234, 32'hFFFF8000);
      load_case("lb_pos", 5'd6, 3'b000, 2'd1, 32'h00007F00, 32'h0000007F);

      // LW with delayed memory and dependency stall
      exp_q.push_back({5'd7, 32'hCAFEF00D});
      rd_addr1 = 5'd7;
      issue_load(5'd7, 3'b010, 2'd0);
      @(negedge clk);
      check("wait_ready", {36'h0, instr_ready}, 37'h0);
      check("wait_stall_hit", {36'h0, stall}, 37'h1);
      rd_addr1 = 5'd0;
      #1;
      check("wait_stall_x0", {36'h0, stall}, 37'h0);
      instr_valid = 1'b1; instr_kind = 2'b01; instr_rd = 5'd9; alu_result = 32'h99;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("wait_no_accept", {36'h0, wr_en}, 37'h0);
      mem_resp(32'hCAFEF00D, 2);
      @(negedge clk);
      check("lw_wr_en", {36'h0, wr_en}, 37'h1);
      check("lw_ready_back", {36'h0, instr_ready}, 37'h1);
      @(posedge clk); #1;

      // Misaligned and illegal loads
      issue_load(5'd9, 3'b010, 2'd1);
      @(negedge clk);
      check("mis_pulse", {36'h0, load_misaligned}, 37'h1);
      check("mis_ready", {36'h0, instr_ready}, 37'h1);
      check("mis_no_wr", {36'h0, wr_en}, 37'h0);
      @(negedge clk);
      check("mis_pulse_end", {36'h0, load_misaligned}, 37'h0);
      issue_load(5'd9, 3'b001, 2'd3);
      @(negedge clk);
      check("mis_lh", {36'h0, load_misaligned}, 37'h1);
      @(posedge clk); #1;
      issue_load(5'd9, 3'b011, 2'd0);
      @(negedge clk);
      check("mis_illegal", {36'h0, load_misaligned}, 37'h1);
      mem_resp(32'hBAD0BAD0, 0);
      @(negedge clk);
      check("stray_rvalid", {36'h0, wr_en}, 37'h0);
      @(posedge clk); #1;

      // Back-to-back ALU writes
      rd_addr2 = 5'd3;
      exp_q.push_back({5'd3, 32'h33});
      instr_valid = 1'b1; instr_kind = 2'b01; instr_rd = 5'd3; alu_result = 32'h33;
      @(posedge clk); #1;
      exp_q.push_back({5'd4, 32'h44});
      instr_rd = 5'd4; alu_result = 32'h44;
      @(negedge clk);
`ifdef WB_BYPASS_EN
      check("b2b_byp_hit2", {36'h0, byp_hit2}, 37'h1);
      check("b2b_byp_data", {5'h0, byp_data}, {5'h0, 32'h33});
      check("b2b_stall", {36'h0, stall}, 37'h0);
`else
      check("b2b_stall", {36'h0, stall}, 37'h1);
`endif
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("b2b_second", {32'h0, rw_addr}, {32'h0, 5'd4});
      check("b2b_stall_off", {36'h0, stall}, 37'h0);
      rd_addr2 = 5'd0;
      @(posedge clk); #1;

      // Reset during WAIT_MEM drops the pending load
      issue_load(5'd10, 3'b010, 2'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {36'h0, instr_ready}, 37'h1);
      check("rst_mid_wr_en", {36'h0, wr_en}, 37'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_resp(32'h0F0F0F0F, 0);
      @(negedge clk);
      check("rst_mid_no_wr", {36'h0, wr_en}, 37'h0);
      check("rst_mid_ready2", {36'h0, instr_ready}, 37'h1);
      repeat (3) @(posedge clk);

      check("sb_drained", {5'h0, 32'(exp_q.size())}, 37'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
